// File: rtl/bit_unstuffer.sv
// bit_unstuffer: removes stuffed zeros after runs of six ones in a received
// serial stream, counts removed bits per packet and flags stuffing violations.
// Optional feature macro: UNSTUFF_ERR_DETECT_EN (enables ERR state and stuff_err).
//
// state | meaning
// IDLE  | no packet in progress (idle cycle seen or out of reset)
// RUN   | passing bits through, counting consecutive ones
// STUFF | six ones seen; next valid bit is the stuff bit
// ERR   | stuff bit was a 1; drop everything until the packet ends
module bit_unstuffer (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       bstr_in,
  input  logic [1:0] bstr_in_ready,
  output logic       bstr_out,
  output logic [1:0] bstr_out_ready,
  output logic [5:0] unstuffed,
  output logic       stuff_err
);

`ifdef UNSTUFF_ERR_DETECT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STUFF = 2'd2, ERR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STUFF = 2'd2} state_t;
`endif

  state_t     state_q, state_d, cur_state;
  logic [2:0] ones_q, ones_d, cur_ones;
  logic [1:0] prev_type_q, prev_type_d;
  logic       out_q, out_d;
  logic [1:0] out_rdy_q, out_rdy_d;
  logic [5:0] unst_q, unst_d;
  logic       pkt_start;
`ifdef UNSTUFF_ERR_DETECT_EN
  logic       err_q, err_d;
`endif

  // State, counters and registered output path
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      ones_q      <= 3'd0;
      prev_type_q <= 2'b00;
      out_q       <= 1'b0;
      out_rdy_q   <= 2'b00;
      unst_q      <= 6'd0;
`ifdef UNSTUFF_ERR_DETECT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      prev_type_q <= prev_type_d;
      out_q       <= out_d;
      out_rdy_q   <= out_rdy_d;
      unst_q      <= unst_d;
`ifdef UNSTUFF_ERR_DETECT_EN
      err_q       <= err_d;
`endif
    end
  end

  // Next-state logic: a packet start restarts processing in RUN with a clear counter
  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    prev_type_d = prev_type_q;
    out_d       = 1'b0;
    out_rdy_d   = 2'b00;
    unst_d      = unst_q;
`ifdef UNSTUFF_ERR_DETECT_EN
    err_d       = err_q;
`endif
    cur_state   = state_q;
    cur_ones    = ones_q;
    pkt_start   = (bstr_in_ready != 2'b00) &&
                  ((state_q == IDLE) || (bstr_in_ready != prev_type_q));

    if (bstr_in_ready == 2'b00) begin
      state_d = IDLE;
      ones_d  = 3'd0;
    end else begin
      prev_type_d = bstr_in_ready;
      if (pkt_start) begin
        cur_state = RUN;
        cur_ones  = 3'd0;
        unst_d    = 6'd0;
`ifdef UNSTUFF_ERR_DETECT_EN
        err_d     = 1'b0;
`endif
      end
      case (cur_state)
        RUN: begin
          out_d     = bstr_in;
          out_rdy_d = bstr_in_ready;
          if (bstr_in) begin
            ones_d  = cur_ones + 3'd1;
            state_d = (cur_ones == 3'd5) ? STUFF : RUN;
          end else begin
            ones_d  = 3'd0;
            state_d = RUN;
          end
        end
        STUFF: begin
`ifdef UNSTUFF_ERR_DETECT_EN
          if (bstr_in) begin
            state_d = ERR;
            err_d   = 1'b1;
            ones_d  = 3'd0;
          end else begin
            state_d = RUN;
            ones_d  = 3'd0;
            if (unst_q != 6'd63) unst_d = unst_q + 6'd1;
          end
`else
          state_d = RUN;
          ones_d  = 3'd0;
          if (unst_q != 6'd63) unst_d = unst_q + 6'd1;
`endif
        end
`ifdef UNSTUFF_ERR_DETECT_EN
        ERR: begin
          state_d = ERR;
        end
`endif
        default: begin
          state_d = IDLE;
          ones_d  = 3'd0;
        end
      endcase
    end
  end

  assign bstr_out       = out_q;
  assign bstr_out_ready = out_rdy_q;
  assign unstuffed      = unst_q;
`ifdef UNSTUFF_ERR_DETECT_EN
  assign stuff_err      = err_q;
`else
  assign stuff_err      = 1'b0;
`endif

endmodule

// File: tb/tb_bit_unstuffer.sv
// tb_bit_unstuffer: directed scenarios for bit_unstuffer with a behavioural
// reference model feeding a scoreboard queue of expected output beats.
module tb_bit_unstuffer;

`ifdef UNSTUFF_ERR_DETECT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_b;
  logic       bstr_in;
  logic [1:0] bstr_in_ready;
  logic       bstr_out;
  logic [1:0] bstr_out_ready;
  logic [5:0] unstuffed;
  logic       stuff_err;

  int vectors = 0;
  int miscompares = 0;
  int n_out = 0;

  // reference model state: 0 idle, 1 run, 2 stuff, 3 err
  int         m_state = 0;
  int         m_ones = 0;
  logic [1:0] m_prev = 2'b00;
  int         m_unst = 0;
  logic       m_err = 1'b0;

  logic [2:0] sb[$];

  bit_unstuffer dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .bstr_in        (bstr_in),
    .bstr_in_ready  (bstr_in_ready),
    .bstr_out       (bstr_out),
    .bstr_out_ready (bstr_out_ready),
    .unstuffed      (unstuffed),
    .stuff_err      (stuff_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ones  = 0;
    m_prev  = 2'b00;
    m_unst  = 0;
    m_err   = 1'b0;
  endtask

  // expected {type, bit} for the beat produced by this input
  task automatic model(input logic [1:0] t, input logic b, output logic [2:0] e);
    bit keep;
    keep = 1'b0;
    if (t == 2'b00) begin
      m_state = 0;
      m_ones  = 0;
    end else begin
      if (m_state == 0 || t != m_prev) begin
        m_state = 1;
        m_ones  = 0;
        m_unst  = 0;
        m_err   = 1'b0;
      end
      m_prev = t;
      if (m_state == 1) begin
        keep = 1'b1;
        m_ones = b ? m_ones + 1 : 0;
        if (m_ones == 6) m_state = 2;
      end else if (m_state == 2) begin
        if (b && ERR_EN) begin
          m_state = 3;
          m_err   = 1'b1;
        end else begin
          m_state = 1;
          m_ones  = 0;
          if (m_unst < 63) m_unst = m_unst + 1;
        end
      end
    end
    e = keep ? {t, b} : 3'b000;
  endtask

  task automatic step(input logic [1:0] t, input logic b);
    logic [2:0] e;
    @(negedge clk);
    bstr_in_ready = t;
    bstr_in       = b;
    model(t, b, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("out_rdy", {6'd0, bstr_out_ready}, {5'd0, e[2:1]});
    check("out_bit", {7'd0, bstr_out}, {7'd0, e[0]});
    check("unstuffed", {2'd0, unstuffed}, m_unst[7:0]);
    check("stuff_err", {7'd0, stuff_err}, {7'd0, m_err});
    if (bstr_out_ready != 2'b00) n_out++;
  endtask

  task automatic ones(input logic [1:0] t, input int n);
    for (int i = 0; i < n; i++) step(t, 1'b1);
  endtask

  initial begin
    rst_b         = 1'b0;
    bstr_in       = 1'b0;
    bstr_in_ready = 2'b00;
    model_reset();
    #3;
    check("rst_out", {7'd0, bstr_out}, 8'd0);
    check("rst_rdy", {6'd0, bstr_out_ready}, 8'd0);
    check("rst_unst", {2'd0, unstuffed}, 8'd0);
    check("rst_err", {7'd0, stuff_err}, 8'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // six ones, stuffed zero removed, data continues
    n_out = 0;
    ones(2'b01, 6);
    step(2'b01, 1'b0);
    step(2'b01, 1'b1);
    step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    check("s1_unst", {2'd0, unstuffed}, 8'd1);
    check("s1_nout", n_out[7:0], 8'd8);
    check("s1_err", {7'd0, stuff_err}, 8'd0);

    // stuffing violation
    n_out = 0;
    ones(2'b10, 6);
    step(2'b10, 1'b1);
    step(2'b10, 1'b0);
    step(2'b10, 1'b1);
    step(2'b00, 1'b0);
    step(2'b00, 1'b0);
    check("s2_err", {7'd0, stuff_err}, {7'd0, ERR_EN});
    check("s2_nout", n_out[7:0], ERR_EN ? 8'd6 : 8'd8);
    check("s2_unst", {2'd0, unstuffed}, ERR_EN ? 8'd0 : 8'd1);

    // 64 bits of (1x6, 0): ones count carries across byte boundaries
    n_out = 0;
    for (int i = 0; i < 64; i++) step(2'b01, (i % 7) != 6);
    step(2'b00, 1'b0);
    check("s3_unst", {2'd0, unstuffed}, 8'd9);
    check("s3_nout", n_out[7:0], 8'd55);

    // packet ends on the sixth one, then a fresh packet
    ones(2'b01, 6);
    step(2'b00, 1'b0);
    check("s4_err_idle", {7'd0, stuff_err}, 8'd0);
    n_out = 0;
    step(2'b01, 1'b0);
    check("s4_first", {5'd0, bstr_out_ready, bstr_out}, {5'd0, 2'b01, 1'b0});
    step(2'b01, 1'b1);
    step(2'b00, 1'b0);
    check("s4_unst", {2'd0, unstuffed}, 8'd0);

    // asynchronous reset mid-packet
    ones(2'b11, 4);
    rst_b = 1'b0;
    #2;
    check("s5_out", {7'd0, bstr_out}, 8'd0);
    check("s5_rdy", {6'd0, bstr_out_ready}, 8'd0);
    check("s5_unst", {2'd0, unstuffed}, 8'd0);
    model_reset();
    rst_b = 1'b1;
    ones(2'b11, 6);
    step(2'b11, 1'b0);
    step(2'b11, 1'b1);
    step(2'b00, 1'b0);
    check("s5_unst_after", {2'd0, unstuffed}, 8'd1);

    // type switch after five ones restarts the ones count
    ones(2'b01, 5);
    n_out = 0;
    step(2'b11, 1'b1);
    step(2'b11, 1'b1);
    step(2'b11, 1'b0);
    step(2'b00, 1'b0);
    check("s6_nout", n_out[7:0], 8'd3);
    check("s6_unst", {2'd0, unstuffed}, 8'd0);

    // unstuffed saturates at 63
    for (int i = 0; i < 70 * 7; i++) step(2'b10, (i % 7) != 6);
    step(2'b00, 1'b0);
    check("s7_sat", {2'd0, unstuffed}, 8'd63);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
